// File: rtl/sys_arr_pkg.sv
// Shared definitions for the weight-stationary systolic array.
// Holds the controller state encoding and the fixed input-to-output
// latency of the array, so the top level and anyone sizing buffers
// around it derive the same number.
package sys_arr_pkg;

    // Controller states: IDLE before any weights exist, LOAD while weight
    // rows are streaming in, STREAM while input vectors are accepted.
    typedef enum logic [1:0] {
        WS_IDLE,
        WS_LOAD,
        WS_STREAM
    } ws_state_t;

    // Cycles from the accepting edge of an input vector to the edge that
    // raises out_valid for it, with the pipeline enabled throughout.
    function automatic int ws_latency(input int rows, input int cols);
        return rows + cols;
    endfunction

endpackage

// File: rtl/sysarr_ws_pe.sv
// One processing element of the weight-stationary array.
// Holds a single weight, forwards the input element to its right-hand
// neighbour and the running partial sum to the PE below, one register each.
// Ports:
//   clk, RST   clock and synchronous active-high reset
//   en_i       pipeline enable; when low the x, valid and psum registers hold
//   w_we_i     weight write strobe, independent of en_i
//   w_i        new weight value
//   x_i/x_o    input element in / registered copy out (to the right)
//   valid_i/valid_o  vector-valid tag travelling with x
//   psum_i/psum_o    partial sum in (from above) / registered sum out (below)
module sysarr_ws_pe
    import sys_arr_pkg::*;
#(
    parameter int DW    = 8,
    parameter int ACC_W = 32
) (
    input  logic                    clk,
    input  logic                    RST,
    input  logic                    en_i,
    input  logic                    w_we_i,
    input  logic signed [DW-1:0]    w_i,
    input  logic signed [DW-1:0]    x_i,
    input  logic                    valid_i,
    input  logic signed [ACC_W-1:0] psum_i,
    output logic signed [DW-1:0]    x_o,
    output logic                    valid_o,
    output logic signed [ACC_W-1:0] psum_o
);

    localparam int PW = 2 * DW;

    logic signed [DW-1:0]    w_q;
    logic signed [DW-1:0]    x_q;
    logic                    valid_q;
    logic signed [ACC_W-1:0] psum_q;

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] psum_d;

    // Full-width signed product, then sign-extended to the accumulator width.
    // The add wraps modulo 2^ACC_W on purpose; there is no saturation.
    always_comb begin
        prod   = PW'(x_i) * PW'(w_q);
        psum_d = psum_i + ACC_W'(prod);
    end

    // The weight only changes on an explicit write, so it survives pipeline
    // stalls. Everything else moves one step per enabled cycle.
    always_ff @(posedge clk) begin
        if (RST) begin
            w_q     <= '0;
            x_q     <= '0;
            valid_q <= 1'b0;
            psum_q  <= '0;
        end else begin
            if (w_we_i) begin
                w_q <= w_i;
            end
            if (en_i) begin
                x_q     <= x_i;
                valid_q <= valid_i;
                psum_q  <= psum_d;
            end
        end
    end

    assign x_o     = x_q;
    assign valid_o = valid_q;
    assign psum_o  = psum_q;

endmodule

// File: rtl/systolic_array_ws_stream.sv
// Weight-stationary ROWSxCOLS integer systolic array with streaming I/O.
// Computes y[c] = bias[c] + sum_r x[r]*W[r][c] for one vector per cycle,
// with input skew, output de-skew and full ready/valid backpressure.
// Ports:
//   clk, RST              clock and synchronous active-high reset
//   w_valid/w_ready/w_row weight row beats, row 0 first; element c at slice c
//   in_valid/in_ready     input vector handshake
//   in_vec                input vector x, element r at slice r
//   in_acc/in_bias        when in_acc is set, in_bias seeds each column's sum
//   out_valid/out_ready   result handshake
//   out_vec               result vector y, element c at slice c
//   drained               high when no vector is in flight
module systolic_array_ws_stream
    import sys_arr_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int DW    = 8,
    parameter int ACC_W = 32
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [COLS*DW-1:0]    w_row,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ROWS*DW-1:0]    in_vec,
    input  logic                  in_acc,
    input  logic [COLS*ACC_W-1:0] in_bias,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [COLS*ACC_W-1:0] out_vec,
    output logic                  drained
);

    localparam int LAT = ws_latency(ROWS, COLS);
    localparam int IFW = $clog2(LAT + 2);
    localparam int RCW = (ROWS > 1) ? $clog2(ROWS) : 1;

    ws_state_t         state_q;
    logic [RCW-1:0]    rowCnt_q;
    logic [IFW-1:0]    inflight_q;
    logic              outValid_q;

    logic              en;
    logic              wAccept;
    logic              inAccept;
    logic              outFire;
    logic [RCW-1:0]    wRowSel;
    logic [ROWS-1:0]   wWe;
    logic              lastValid;

    // Interconnect: xH/vH run left to right along a row, pV runs top to
    // bottom along a column (pV[0] is the skewed bias, pV[ROWS] the result).
    logic signed [DW-1:0]    xH [ROWS][COLS];
    logic                    vH [ROWS][COLS];
    logic signed [ACC_W-1:0] pV [ROWS+1][COLS];

    // The x and valid leaving the last column have nowhere to go.
    logic signed [DW-1:0]    xEdge_unused [ROWS];
    logic                    vEdge_unused [ROWS];

    // One global enable: the whole pipeline advances only when the output
    // register is free or being emptied this cycle, which keeps every
    // vector's skewed pieces aligned under backpressure.
    assign en       = !outValid_q || out_ready;
    assign drained  = (inflight_q == '0);

    // Ready signals stay combinational because they must see out_ready in
    // the same cycle. A pending weight beat wins over input once drained,
    // and weights are never touched while a vector is in flight.
    assign w_ready  = (state_q != WS_STREAM) || drained;
    assign in_ready = (state_q == WS_STREAM) && en && !(w_valid && drained);

    assign wAccept  = w_valid && w_ready;
    assign inAccept = in_valid && in_ready;
    assign outFire  = outValid_q && out_ready;

    // Only LOAD writes rows beyond 0; any beat taken in IDLE or STREAM is
    // the first row of a fresh weight set.
    assign wRowSel  = (state_q == WS_LOAD) ? rowCnt_q : '0;

    // Controller: counts weight rows in, then opens the input stream. A new
    // weight beat during STREAM restarts a full reload from row 0.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q  <= WS_IDLE;
            rowCnt_q <= '0;
        end else begin
            case (state_q)
                WS_IDLE, WS_STREAM: begin
                    if (wAccept) begin
                        if (ROWS == 1) begin
                            state_q  <= WS_STREAM;
                            rowCnt_q <= '0;
                        end else begin
                            state_q  <= WS_LOAD;
                            rowCnt_q <= RCW'(1);
                        end
                    end
                end
                WS_LOAD: begin
                    if (wAccept) begin
                        if (rowCnt_q == RCW'(ROWS - 1)) begin
                            state_q  <= WS_STREAM;
                            rowCnt_q <= '0;
                        end else begin
                            rowCnt_q <= rowCnt_q + RCW'(1);
                        end
                    end
                end
                default: begin
                    state_q  <= WS_IDLE;
                    rowCnt_q <= '0;
                end
            endcase
        end
    end

    // Vectors in flight: accepted but not yet handed to the consumer.
    always_ff @(posedge clk) begin
        if (RST) begin
            inflight_q <= '0;
        end else begin
            case ({inAccept, outFire})
                2'b10:   inflight_q <= inflight_q + IFW'(1);
                2'b01:   inflight_q <= inflight_q - IFW'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // Result valid flag, taken from the bottom-right PE which is the last
    // cell each vector passes through.
    always_ff @(posedge clk) begin
        if (RST) begin
            outValid_q <= 1'b0;
        end else if (en) begin
            outValid_q <= lastValid;
        end
    end

    assign out_valid = outValid_q;

    // Per-row input skew: row r sees its element r cycles after row 0, so the
    // diagonal wavefront meets the partial sums coming down each column.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic signed [DW-1:0] xSkew_q [r+1];
        logic                 vSkew_q [r+1];

        always_ff @(posedge clk) begin
            if (RST) begin
                for (int i = 0; i <= r; i++) begin
                    xSkew_q[i] <= '0;
                    vSkew_q[i] <= 1'b0;
                end
            end else if (en) begin
                xSkew_q[0] <= in_vec[(r+1)*DW-1 -: DW];
                vSkew_q[0] <= inAccept;
                for (int i = 1; i <= r; i++) begin
                    xSkew_q[i] <= xSkew_q[i-1];
                    vSkew_q[i] <= vSkew_q[i-1];
                end
            end
        end

        assign xH[r][0] = xSkew_q[r];
        assign vH[r][0] = vSkew_q[r];
        assign wWe[r]   = wAccept && (wRowSel == RCW'(r));
    end

    // Per-column bias skew on the way in and de-skew on the way out. Column c
    // starts c cycles after column 0, so it is delayed COLS-c stages at the
    // bottom; the last stage of each chain is the output register itself.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic signed [ACC_W-1:0] bSkew_q [c+1];
        logic signed [ACC_W-1:0] dSkew_q [COLS-c];

        always_ff @(posedge clk) begin
            if (RST) begin
                for (int i = 0; i <= c; i++) begin
                    bSkew_q[i] <= '0;
                end
            end else if (en) begin
                bSkew_q[0] <= in_acc ? in_bias[(c+1)*ACC_W-1 -: ACC_W] : '0;
                for (int i = 1; i <= c; i++) begin
                    bSkew_q[i] <= bSkew_q[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (RST) begin
                for (int i = 0; i < COLS - c; i++) begin
                    dSkew_q[i] <= '0;
                end
            end else if (en) begin
                dSkew_q[0] <= pV[ROWS][c];
                for (int i = 1; i < COLS - c; i++) begin
                    dSkew_q[i] <= dSkew_q[i-1];
                end
            end
        end

        assign pV[0][c] = bSkew_q[c];
        assign out_vec[(c+1)*ACC_W-1 -: ACC_W] = dSkew_q[COLS-c-1];
    end

    // The PE grid. Every PE in column c takes its weight from slice c of the
    // current weight beat; the row strobe picks which row latches it.
    for (genvar r = 0; r < ROWS; r++) begin : g_pe_row
        for (genvar c = 0; c < COLS; c++) begin : g_pe_col
            logic signed [DW-1:0] xOut;
            logic                 vOut;

            sysarr_ws_pe #(
                .DW    (DW),
                .ACC_W (ACC_W)
            ) u_pe (
                .clk     (clk),
                .RST     (RST),
                .en_i    (en),
                .w_we_i  (wWe[r]),
                .w_i     (w_row[(c+1)*DW-1 -: DW]),
                .x_i     (xH[r][c]),
                .valid_i (vH[r][c]),
                .psum_i  (pV[r][c]),
                .x_o     (xOut),
                .valid_o (vOut),
                .psum_o  (pV[r+1][c])
            );

            if (c < COLS - 1) begin : g_pass
                assign xH[r][c+1] = xOut;
                assign vH[r][c+1] = vOut;
            end else begin : g_edge
                assign xEdge_unused[r] = xOut;
                assign vEdge_unused[r] = vOut;
                if (r == ROWS - 1) begin : g_last
                    assign lastValid = vOut;
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_array_ws_stream.sv
// Directed self-checking bench for systolic_array_ws_stream at the default
// 4x4, 8-bit data, 32-bit accumulator configuration.
module tb_systolic_array_ws_stream;

    logic         clk = 1'b0;
    logic         RST;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_row;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_vec;
    logic         in_acc;
    logic [127:0] in_bias;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_vec;
    logic         drained;

    int nTests = 0;
    int nFail  = 0;

    // Weight sets, row r at bits [r*32 +: 32], element c of a row at [c*8 +: 8].
    localparam logic [127:0] W_IDENT = {32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001};
    localparam logic [127:0] W_2I    = {32'h02000000, 32'h00020000, 32'h00000200, 32'h00000002};
    localparam logic [127:0] W_M128  = {16{8'h80}};
    localparam logic [127:0] W_P127  = {16{8'h7F}};

    logic [31:0] vecs [6] = '{32'h04030201, 32'h08070605, 32'hFFFEFDFC,
                              32'h7F80017F, 32'h11223344, 32'h00000000};

    systolic_array_ws_stream #(
        .ROWS  (4),
        .COLS  (4),
        .DW    (8),
        .ACC_W (32)
    ) dut (
        .clk       (clk),
        .RST       (RST),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_row     (w_row),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .in_acc    (in_acc),
        .in_bias   (in_bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .drained   (drained)
    );

    always #5 clk = ~clk;

    // With identity weights and no bias, y is just x sign-extended per element.
    function automatic logic [127:0] sextVec(input logic [31:0] x);
        logic [127:0] res;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            res[r*32 +: 32] = {{24{x[r*8+7]}}, x[r*8 +: 8]};
        end
        return res;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic loadRows(input logic [127:0] wAll);
        for (int r = 0; r < 4; r++) begin
            w_valid = 1'b1;
            w_row   = wAll[r*32 +: 32];
            step();
        end
        w_valid = 1'b0;
    endtask

    // Offer one vector, then wait (bounded) for out_valid; lat counts edges
    // after the accepting edge.
    task automatic sendOne(input logic [31:0] x, input logic acc, input logic [127:0] bias,
                           output logic rdy, output int lat, output logic [127:0] y);
        in_vec   = x;
        in_acc   = acc;
        in_bias  = bias;
        in_valid = 1'b1;
        #1;
        rdy = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 30) begin
            step();
            lat++;
        end
        y = out_vec;
    endtask

    task automatic test_reset();
        RST = 1'b1; w_valid = 1'b0; w_row = '0; in_valid = 1'b0; in_vec = '0;
        in_acc = 1'b0; in_bias = '0; out_ready = 1'b1;
        step();
        step();
        nTests++; if (w_ready !== 1'b1) begin nFail++; $display("[TB] FAIL reset_w_ready: got %b expected 1", w_ready); end
        nTests++; if (in_ready !== 1'b0) begin nFail++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
        nTests++; if (out_valid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        nTests++; if (out_vec !== 128'd0) begin nFail++; $display("[TB] FAIL reset_out_vec: got %h expected 0", out_vec); end
        nTests++; if (drained !== 1'b1) begin nFail++; $display("[TB] FAIL reset_drained: got %b expected 1", drained); end
        RST = 1'b0;
        in_valid = 1'b1;
        #1;
        nTests++; if (in_ready !== 1'b0) begin nFail++; $display("[TB] FAIL idle_in_ready: got %b expected 0", in_ready); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_identity();
        logic rdy; int lat; logic [127:0] y;
        loadRows(W_IDENT);
        sendOne(32'h04030201, 1'b0, '0, rdy, lat, y);
        nTests++; if (rdy !== 1'b1) begin nFail++; $display("[TB] FAIL ident_in_ready: got %b expected 1", rdy); end
        nTests++; if (lat !== 8) begin nFail++; $display("[TB] FAIL ident_latency: got %0d expected 8", lat); end
        nTests++; if (y !== {32'd4, 32'd3, 32'd2, 32'd1}) begin nFail++; $display("[TB] FAIL ident_result: got %h expected %h", y, {32'd4, 32'd3, 32'd2, 32'd1}); end
        step();
        nTests++; if (drained !== 1'b1) begin nFail++; $display("[TB] FAIL ident_drained: got %b expected 1", drained); end
        nTests++; if (out_valid !== 1'b0) begin nFail++; $display("[TB] FAIL ident_out_valid_drop: got %b expected 0", out_valid); end
    endtask

    task automatic test_bias();
        logic rdy; int lat; logic [127:0] y;
        sendOne(32'h04030201, 1'b1, {32'd40, 32'd30, 32'd20, 32'd10}, rdy, lat, y);
        nTests++; if (y !== {32'd44, 32'd33, 32'd22, 32'd11}) begin nFail++; $display("[TB] FAIL bias_acc: got %h expected %h", y, {32'd44, 32'd33, 32'd22, 32'd11}); end
        step();
        sendOne(32'h04030201, 1'b0, {32'd40, 32'd30, 32'd20, 32'd10}, rdy, lat, y);
        nTests++; if (y !== {32'd4, 32'd3, 32'd2, 32'd1}) begin nFail++; $display("[TB] FAIL bias_ignored: got %h expected %h", y, {32'd4, 32'd3, 32'd2, 32'd1}); end
        step();
    endtask

    task automatic test_extremes();
        logic rdy; int lat; logic [127:0] y;
        loadRows(W_M128);
        sendOne(32'h80808080, 1'b0, '0, rdy, lat, y);
        nTests++; if (y !== {4{32'h00010000}}) begin nFail++; $display("[TB] FAIL neg_times_neg: got %h expected %h", y, {4{32'h00010000}}); end
        step();
        loadRows(W_P127);
        sendOne(32'h80808080, 1'b0, '0, rdy, lat, y);
        nTests++; if (y !== {4{32'hFFFF0200}}) begin nFail++; $display("[TB] FAIL pos_times_neg: got %h expected %h", y, {4{32'hFFFF0200}}); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [127:0] got [$];
        logic [127:0] held;
        int sent, cyc, stallLeft;
        bit stallSeen, holdBad, readyBad;
        sent = 0; cyc = 0; stallLeft = 0;
        stallSeen = 0; holdBad = 0; readyBad = 0; held = '0;
        loadRows(W_IDENT);
        in_acc = 1'b0;
        while (got.size() < 6 && cyc < 100) begin
            if (out_valid === 1'b1 && !stallSeen) begin
                stallSeen = 1;
                stallLeft = 3;
                held      = out_vec;
            end
            if (stallLeft > 0) begin
                out_ready = 1'b0;
                stallLeft--;
            end else begin
                out_ready = 1'b1;
            end
            if (sent < 6) begin
                in_valid = 1'b1;
                in_vec   = vecs[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_ready == 1'b0) begin
                if (out_vec !== held) holdBad = 1;
                if (in_ready !== 1'b0) readyBad = 1;
            end
            if (in_valid && in_ready === 1'b1) sent++;
            if (out_valid === 1'b1 && out_ready) got.push_back(out_vec);
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        nTests++; if (stallSeen !== 1'b1) begin nFail++; $display("[TB] FAIL b2b_first_valid: got %b expected 1", stallSeen); end
        nTests++; if (holdBad !== 1'b0) begin nFail++; $display("[TB] FAIL b2b_out_held: got %b expected 0", holdBad); end
        nTests++; if (readyBad !== 1'b0) begin nFail++; $display("[TB] FAIL b2b_in_ready_stall: got %b expected 0", readyBad); end
        nTests++; if (got.size() !== 6) begin nFail++; $display("[TB] FAIL b2b_count: got %0d expected 6", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            nTests++;
            if (got[i] !== sextVec(vecs[i])) begin
                nFail++;
                $display("[TB] FAIL b2b_result_%0d: got %h expected %h", i, got[i], sextVec(vecs[i]));
            end
        end
        nTests++; if (drained !== 1'b1) begin nFail++; $display("[TB] FAIL b2b_drained: got %b expected 1", drained); end
    endtask

    task automatic test_reload_hold();
        logic [127:0] got [$];
        logic rdy; int lat; logic [127:0] y;
        int cyc;
        bit wrBad, sawDrain;
        logic wrAtDrain;
        cyc = 0; wrBad = 0; sawDrain = 0; wrAtDrain = 1'b0;
        out_ready = 1'b1;
        in_acc    = 1'b0;
        in_valid  = 1'b1;
        in_vec    = 32'h04030201;
        step();
        in_vec    = 32'h08070605;
        step();
        in_valid  = 1'b0;
        w_valid   = 1'b1;
        w_row     = W_2I[31:0];
        while (cyc < 40) begin
            #1;
            if (out_valid === 1'b1 && out_ready) got.push_back(out_vec);
            if (drained === 1'b1) begin
                sawDrain  = 1;
                wrAtDrain = w_ready;
                break;
            end
            if (w_ready !== 1'b0) wrBad = 1;
            step();
            cyc++;
        end
        nTests++; if (sawDrain !== 1'b1) begin nFail++; $display("[TB] FAIL reload_drained: got %b expected 1", sawDrain); end
        nTests++; if (wrBad !== 1'b0) begin nFail++; $display("[TB] FAIL reload_w_ready_inflight: got %b expected 0", wrBad); end
        nTests++; if (wrAtDrain !== 1'b1) begin nFail++; $display("[TB] FAIL reload_w_ready_drained: got %b expected 1", wrAtDrain); end
        step();
        in_valid = 1'b1;
        in_vec   = 32'h04030201;
        #1;
        nTests++; if (in_ready !== 1'b0) begin nFail++; $display("[TB] FAIL load_in_ready: got %b expected 0", in_ready); end
        in_valid = 1'b0;
        for (int r = 1; r < 4; r++) begin
            w_row = W_2I[r*32 +: 32];
            step();
        end
        w_valid = 1'b0;
        nTests++; if (got.size() !== 2) begin nFail++; $display("[TB] FAIL reload_old_count: got %0d expected 2", got.size()); end
        if (got.size() >= 1) begin
            nTests++; if (got[0] !== {32'd4, 32'd3, 32'd2, 32'd1}) begin nFail++; $display("[TB] FAIL reload_old_0: got %h expected %h", got[0], {32'd4, 32'd3, 32'd2, 32'd1}); end
        end
        if (got.size() >= 2) begin
            nTests++; if (got[1] !== {32'd8, 32'd7, 32'd6, 32'd5}) begin nFail++; $display("[TB] FAIL reload_old_1: got %h expected %h", got[1], {32'd8, 32'd7, 32'd6, 32'd5}); end
        end
        sendOne(32'h04030201, 1'b0, '0, rdy, lat, y);
        nTests++; if (y !== {32'd8, 32'd6, 32'd4, 32'd2}) begin nFail++; $display("[TB] FAIL reload_new_weights: got %h expected %h", y, {32'd8, 32'd6, 32'd4, 32'd2}); end
        step();
    endtask

    task automatic test_reset_midflight();
        logic rdy; int lat; logic [127:0] y;
        bit stale;
        stale = 0;
        out_ready = 1'b1;
        in_acc    = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_vec = vecs[i];
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        RST      = 1'b1;
        in_valid = 1'b1;
        step();
        nTests++; if (out_valid !== 1'b0) begin nFail++; $display("[TB] FAIL rst_mid_out_valid: got %b expected 0", out_valid); end
        nTests++; if (in_ready !== 1'b0) begin nFail++; $display("[TB] FAIL rst_mid_in_ready: got %b expected 0", in_ready); end
        nTests++; if (drained !== 1'b1) begin nFail++; $display("[TB] FAIL rst_mid_drained: got %b expected 1", drained); end
        nTests++; if (w_ready !== 1'b1) begin nFail++; $display("[TB] FAIL rst_mid_w_ready: got %b expected 1", w_ready); end
        RST      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid !== 1'b0) stale = 1;
        end
        nTests++; if (stale !== 1'b0) begin nFail++; $display("[TB] FAIL rst_mid_stale_output: got %b expected 0", stale); end
        loadRows(W_IDENT);
        sendOne(32'h04030201, 1'b0, '0, rdy, lat, y);
        nTests++; if (lat !== 8) begin nFail++; $display("[TB] FAIL rst_recover_latency: got %0d expected 8", lat); end
        nTests++; if (y !== {32'd4, 32'd3, 32'd2, 32'd1}) begin nFail++; $display("[TB] FAIL rst_recover_result: got %h expected %h", y, {32'd4, 32'd3, 32'd2, 32'd1}); end
        step();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_bias();
        test_extremes();
        test_back_to_back();
        test_reload_hold();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    // Hard stop in case a wait outside the bounded loops ever hangs.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
